// File: rtl/decode_stage.sv
// decode_stage: D stage of the F D X M W pipeline.
//
// Takes 13-bit instructions from fetch and registers them with a valid/ready
// handshake. It splits each instruction into register indices, an immediate
// and control flags for X. An 8-entry scoreboard of outstanding register
// writes stalls fetch on RAW hazards. HALT stops the stage until reset, and
// flush drops the registered instruction.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_instr/in_valid     instruction from fetch
//   in_ready              D accepts in_instr this cycle
//   out_valid/out_ready   decoded bundle to X
//   opcode,rd,rs1,rs2,imm registered fields (unused indices read 0)
//   reg_write,mem_read,mem_write,branch,jump  registered controls
//   flush                 drop the registered instruction
//   wb_valid, wb_rd       writeback that retires a scoreboard entry
//   halted                HALT has issued (FSM state)
//   illegal               sticky flag for an accepted illegal opcode
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds its payload while valid && !ready. Once valid is
// raised, it stays high until the transfer occurs, except when flush drops
// the registered bundle.

module decode_stage #(
   parameter int IW     = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IW-1:0]     in_instr,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        opcode,
   output logic [2:0]        rd,
   output logic [2:0]        rs1,
   output logic [2:0]        rs2,
   output logic [DATA_W-1:0] imm,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              branch,
   output logic              jump,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic [2:0]        wb_rd,
   output logic              halted,
   output logic              illegal
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t            state;
   logic [7:0]        sb;
   logic [7:0]        sb_next;
   logic [7:0]        wb_clear;
   logic [7:0]        d_busy;
   logic [7:0]        busy;
   logic              hazard;
   logic              fire;
   logic              accept;

   logic [3:0]        op_in;
   logic [2:0]        f_hi;
   logic [2:0]        f_mid;
   logic [2:0]        f_lo;
   logic [3:0]        d_opcode;
   logic [2:0]        d_rd;
   logic [2:0]        d_rs1;
   logic [2:0]        d_rs2;
   logic [DATA_W-1:0] d_imm;
   logic              d_reg_write;
   logic              d_mem_read;
   logic              d_mem_write;
   logic              d_branch;
   logic              d_jump;
   logic              d_illegal;

   assign op_in = in_instr[12:9];
   assign f_hi  = in_instr[8:6];
   assign f_mid = in_instr[5:3];
   assign f_lo  = in_instr[2:0];

   // Field extraction. Illegal opcodes fall through as NOP with opcode 0.
   always_comb begin
      d_opcode    = 4'd0;
      d_rd        = 3'd0;
      d_rs1       = 3'd0;
      d_rs2       = 3'd0;
      d_imm       = '0;
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_branch    = 1'b0;
      d_jump      = 1'b0;
      d_illegal   = 1'b0;
      case (op_in)
         4'd1, 4'd2, 4'd3, 4'd4: begin
            d_opcode    = op_in;
            d_rd        = f_hi;
            d_rs1       = f_mid;
            d_rs2       = f_lo;
            d_reg_write = (f_hi != 3'd0);
         end
         4'd5, 4'd6: begin
            d_opcode    = op_in;
            d_rd        = f_hi;
            d_rs1       = f_mid;
            d_imm       = DATA_W'($signed(f_lo));
            d_reg_write = (f_hi != 3'd0);
            d_mem_read  = (op_in == 4'd6);
         end
         4'd7: begin
            d_opcode    = op_in;
            d_rs2       = f_hi;
            d_rs1       = f_mid;
            d_imm       = DATA_W'($signed(f_lo));
            d_mem_write = 1'b1;
         end
         4'd8: begin
            d_opcode = op_in;
            d_rs1    = f_hi;
            d_rs2    = f_mid;
            d_imm    = DATA_W'($signed(f_lo));
            d_branch = 1'b1;
         end
         4'd9: begin
            d_opcode = op_in;
            d_imm    = DATA_W'(in_instr[4:0]);
            d_jump   = 1'b1;
         end
         OP_HALT: d_opcode = OP_HALT;
         4'd10, 4'd11, 4'd12, 4'd13, 4'd14: d_illegal = 1'b1;
         default: ;
      endcase
   end

   // Registers a source may not read this cycle. A pending scoreboard entry
   // is bypassed by a same-cycle writeback. The producer still sitting in
   // the D register always blocks.
   assign wb_clear = wb_valid ? (8'd1 << wb_rd) : 8'd0;
   assign d_busy   = (out_valid && reg_write) ? (8'd1 << rd) : 8'd0;
   assign busy     = (sb & ~wb_clear) | d_busy;
   assign hazard   = ((d_rs1 != 3'd0) && busy[d_rs1]) ||
                     ((d_rs2 != 3'd0) && busy[d_rs2]);

   // reset gates in_ready so every output reads 0 while reset is held.
   assign in_ready = reset && (state == ST_RUN) && !flush && !hazard &&
                     (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign fire     = out_valid && out_ready && !flush;
   assign halted   = (state == ST_HALT);

   // The set is applied after the clear, so a same-index set wins.
   // r0 is never tracked.
   assign sb_next = ((sb & ~wb_clear) |
                     ((fire && reg_write) ? (8'd1 << rd) : 8'd0)) & 8'hFE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_RUN;
         sb        <= 8'd0;
         out_valid <= 1'b0;
         opcode    <= 4'd0;
         rd        <= 3'd0;
         rs1       <= 3'd0;
         rs2       <= 3'd0;
         imm       <= '0;
         reg_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         branch    <= 1'b0;
         jump      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         sb <= sb_next;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (fire && opcode == OP_HALT) begin
            // Anything fetch handed over in the HALT issue cycle is discarded.
            out_valid <= 1'b0;
            state     <= ST_HALT;
         end else if (accept) begin
            out_valid <= 1'b1;
            opcode    <= d_opcode;
            rd        <= d_rd;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            imm       <= d_imm;
            reg_write <= d_reg_write;
            mem_read  <= d_mem_read;
            mem_write <= d_mem_write;
            branch    <= d_branch;
            jump      <= d_jump;
            illegal   <= illegal | d_illegal;
         end else if (fire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
